console_uart_tx: RTL and testbench
==================================

Name: console_uart_tx

Overview:
- Accepts the core's console writes (`console_we` / `console_wdata`) and buffers them in a small FIFO.
- Drains the FIFO as 8N1 UART frames on the board's TX pin.
- Sits in the FPGA top level beside the seven-segment driver.
- Sequences the otherwise unused console port onto a physical serial line, without ever stalling the core.

Parameters:
- XLEN, 32, width of `console_wdata` as driven by the core.
- CLK_HZ, 100000000, `clk` frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ / BAUD, integer division, must be >= 2.
- FIFO_DEPTH, 16, byte entries; must be a power of two, >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (single clock domain; polarity and async-ness fixed).
- console_we  in  1  one-cycle write strobe from the core.
- console_wdata  in  XLEN  write data; only [7:0] is used, upper bits ignored.
- tx  out  1  UART serial output, idle high.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- busy  out  1  frame in progress or FIFO non-empty.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (reset=0, async):
  - FIFO empty, FSM IDLE, baud counter 0, bit index 0.
  - tx=1, fifo_full=0, busy=0, overflow=0.
  - Asserting reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits wide, with a wrap bit.
  - empty = pointers equal; full = indices equal and wrap bits differ.
  - Push on console_we=1 when not full.
  - Push while full and no pop that cycle: byte dropped, overflow set to 1 until reset.
  - Push and pop in the same cycle while full: push accepted, count unchanged, overflow not set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into shift register sh[7:0], set tx=0, counter=0, go to START. Otherwise tx=1.
  - START: hold tx=0 for CLKS_PER_BIT cycles. At counter=CLKS_PER_BIT-1: tx=sh[0], bit index=0, counter=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. At the end of a bit, shift sh right and output the next bit, LSB first. After bit 7 completes: tx=1, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end: if FIFO non-empty, pop, tx=0, go to START (back-to-back, no idle gap); else go to IDLE.
- tx is a registered output (no glitches).
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have period 10*CLKS_PER_BIT.
- Latency: console_we in cycle N with FIFO empty and FSM IDLE → FIFO non-empty in N+1 → tx=0 first visible in N+2.
- busy = (state != IDLE) | ~empty.
- fifo_full is combinational from the pointers.
- The baud counter width is sized to hold CLKS_PER_BIT-1; it never wraps other than by explicit reset to 0.

Decomposition:
- Add UART_DEFAULT_BAUD and CONSOLE_FIFO_DEPTH defaults to fpga_constants.vh.
- Define the FSM state encodings as localparams in that include, so the bench can probe states.
- One sub-module: console_fifo, a synchronous FIFO with push/pop/full/empty and the wrap-bit pointers. The UART FSM stays in console_uart_tx.
- Instantiate console_uart_tx in the FPGA top level: connect to the core's console_we / console_wdata, and drive the board's TX pin from tx.

Test Plan (CLK_HZ=4, BAUD=1 → CLKS_PER_BIT=4):
- Single byte: write 0x55 in cycle 10.
  - Expect tx=0 for cycles 12–15.
  - Then data bits 1,0,1,0,1,0,1,0, each held 4 cycles (cycles 16–47).
  - Then tx=1 for cycles 48–51; busy=0 from cycle 52.
- Upper bits ignored and back-to-back: write 0xFFFFFF41 then 0x00000042 on consecutive cycles.
  - Expect frames for 0x41 and 0x42.
  - The second start bit immediately follows the first stop bit: 40-cycle period, no idle cycle.
- Full/overflow: write 17 bytes in 17 consecutive cycles while tx is mid-frame on a prior byte.
  - Expect fifo_full=1 after the 16th accepted push.
  - Expect the 17th byte dropped, overflow=1, and exactly 17 frames total: the prior byte plus 16.
- Push and pop while full: fill the FIFO, then time a write to the cycle the FSM pops.
  - Expect the write accepted, overflow stays 0, fifo_full stays 1.
- Mid-frame reset: assert reset=0 during DATA bit 3 of 0xA5.
  - Expect tx=1 within the same cycle (async), FIFO empty, overflow=0.
  - After release, no frame is emitted until the next write.
- Pointer wrap: stream 40 bytes 0x00–0x27, pacing writes to keep the FIFO non-full.
  - Expect all 40 received in order: the pointers wrap twice without loss.

Source files
------------

// File: rtl/console_uart_tx_pkg.sv
// Shared constants, FSM state encoding and helpers for the console UART transmitter.
package console_uart_tx_pkg;

    localparam int unsigned DEFAULT_CLK_HZ     = 100_000_000;
    localparam int unsigned UART_DEFAULT_BAUD  = 115_200;
    localparam int unsigned CONSOLE_FIFO_DEPTH = 16;

    // Fixed encodings so a bench can probe the state register directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/console_uart_tx_fifo.sv
// Byte FIFO between the core's console strobe and the UART FSM; wrap-bit pointers.
module console_fifo
    import console_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = CONSOLE_FIFO_DEPTH,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/console_uart_tx.sv
// Buffers core console writes and drains them as 8N1 UART frames on tx.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD       = UART_DEFAULT_BAUD,
    parameter int unsigned FIFO_DEPTH = CONSOLE_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            console_we,
    input  logic [XLEN-1:0] console_wdata,
    output logic            tx,
    output logic            fifo_full,
    output logic            busy,
    output logic            overflow
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      r_state;
    uart_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_next;
    logic [7:0]       r_sh;
    logic [7:0]       w_sh_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             r_overflow;
    logic             w_pop;
    logic             w_empty;
    logic [7:0]       w_head;
    logic             w_bit_end;
    logic             w_unused_wdata;

    assign w_unused_wdata = ^console_wdata[XLEN-1:8];

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (console_we),
        .pop   (w_pop),
        .din   (console_wdata[7:0]),
        .dout  (w_head),
        .full  (fifo_full),
        .empty (w_empty)
    );

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_sh    <= w_sh_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (!w_empty) w_state_next = ST_START;
            ST_START: if (w_bit_end) w_state_next = ST_DATA;
            ST_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_next = ST_STOP;
            ST_STOP:  if (w_bit_end) w_state_next = w_empty ? ST_IDLE : ST_START;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // tx is computed one cycle ahead so the pin itself comes straight from a flop.
    always_comb begin
        w_cnt_next = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        w_bit_next = r_bit;
        w_sh_next  = r_sh;
        w_tx_next  = r_tx;
        w_pop      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_tx_next  = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_sh_next = w_head;
                    w_tx_next = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_tx_next  = r_sh[0];
                    w_bit_next = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_tx_next = 1'b1;
                    end else begin
                        w_sh_next  = r_sh >> 1;
                        w_tx_next  = r_sh[1];
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_sh_next = w_head;
                        w_tx_next = 1'b0;
                    end else begin
                        w_tx_next = 1'b1;
                    end
                end
            end
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (console_we && fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign busy     = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx at CLKS_PER_BIT=4 (CLK_HZ=4, BAUD=1).
module tb_console_uart_tx;

    logic        clk;
    logic        reset;
    logic        console_we;
    logic [31:0] console_wdata;
    logic        tx;
    logic        fifo_full;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    console_uart_tx #(
        .XLEN       (32),
        .CLK_HZ     (4),
        .BAUD       (1),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .tx            (tx),
        .fifo_full     (fifo_full),
        .busy          (busy),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the sample where the start bit should first appear; returns at
    // the sample just after the stop bit. Optionally writes wb mid-frame.
    task automatic check_frame(input logic [7:0] b, input bit do_wr,
                               input logic [7:0] wb, input string tag);
        int unsigned idx;
        logic        e;
        for (int i = 0; i < 40; i++) begin
            idx = i / 4;
            if (idx == 0)      e = 1'b0;
            else if (idx == 9) e = 1'b1;
            else               e = b[idx-1];
            chk(tag, {31'b0, tx}, {31'b0, e});
            if (do_wr && i == 5) begin
                console_we    = 1'b1;
                console_wdata = {24'h0, wb};
            end else begin
                console_we = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        console_we    = 1'b1;
        console_wdata = d;
        @(negedge clk);
        console_we    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        console_we    = 1'b0;
        console_wdata = '0;
        @(negedge clk);
        chk("rst_tx",   {31'b0, tx},        32'd1);
        chk("rst_full", {31'b0, fifo_full}, 32'd0);
        chk("rst_busy", {31'b0, busy},      32'd0);
        chk("rst_ovf",  {31'b0, overflow},  32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x55
        wr(32'h55);
        chk("lat_busy", {31'b0, busy}, 32'd1);
        chk("lat_tx",   {31'b0, tx},   32'd1);
        @(negedge clk);
        check_frame(8'h55, 1'b0, 8'h00, "frame55");
        chk("idle55_busy", {31'b0, busy}, 32'd0);
        chk("idle55_tx",   {31'b0, tx},   32'd1);
        repeat (3) @(negedge clk);

        // Upper bits ignored, back-to-back frames
        wr(32'hFFFF_FF41);
        wr(32'h0000_0042);
        check_frame(8'h41, 1'b0, 8'h00, "frame41");
        check_frame(8'h42, 1'b0, 8'h00, "frame42");
        chk("b2b_busy", {31'b0, busy},     32'd0);
        chk("b2b_ovf",  {31'b0, overflow}, 32'd0);
        repeat (3) @(negedge clk);

        // Overflow: 17 writes while a prior frame is in flight
        wr(32'h10);
        @(negedge clk);
        chk("ovf_start", {31'b0, tx}, 32'd0);
        for (int k = 0; k < 15; k++) wr(32'h20 + k);
        chk("ovf_full15", {31'b0, fifo_full}, 32'd0);
        wr(32'h2F);
        chk("ovf_full16", {31'b0, fifo_full}, 32'd1);
        chk("ovf_ovf16",  {31'b0, overflow},  32'd0);
        wr(32'h30);
        chk("ovf_ovf17",  {31'b0, overflow},  32'd1);
        chk("ovf_full17", {31'b0, fifo_full}, 32'd1);
        repeat (23) @(negedge clk);
        for (int k = 0; k < 16; k++) check_frame(8'h20 + 8'(k), 1'b0, 8'h00, "ovf_frame");
        chk("ovf_end_busy", {31'b0, busy},     32'd0);
        chk("ovf_sticky",   {31'b0, overflow}, 32'd1);
        do_reset();
        chk("ovf_clear", {31'b0, overflow}, 32'd0);

        // Push and pop in the same cycle while full
        wr(32'h11);
        @(negedge clk);
        for (int k = 0; k < 16; k++) wr(32'h30 + k);
        chk("pp_full",  {31'b0, fifo_full}, 32'd1);
        chk("pp_ovf0",  {31'b0, overflow},  32'd0);
        repeat (23) @(negedge clk);
        chk("pp_full_pre", {31'b0, fifo_full}, 32'd1);
        chk("pp_tx_stop",  {31'b0, tx},        32'd1);
        wr(32'hEE);
        chk("pp_full_post", {31'b0, fifo_full}, 32'd1);
        chk("pp_ovf_post",  {31'b0, overflow},  32'd0);
        for (int k = 0; k < 16; k++) check_frame(8'h30 + 8'(k), 1'b0, 8'h00, "pp_frame");
        check_frame(8'hEE, 1'b0, 8'h00, "pp_frameEE");
        chk("pp_end_busy", {31'b0, busy},     32'd0);
        chk("pp_end_ovf",  {31'b0, overflow}, 32'd0);
        repeat (3) @(negedge clk);

        // Mid-frame asynchronous reset during DATA bit 3 of 0xA5
        wr(32'hA5);
        @(negedge clk);
        wr(32'h77);
        repeat (16) @(negedge clk);
        chk("mr_bit3", {31'b0, tx},   32'd0);
        chk("mr_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_tx_async", {31'b0, tx},        32'd1);
        chk("mr_busy0",    {31'b0, busy},      32'd0);
        chk("mr_full0",    {31'b0, fifo_full}, 32'd0);
        chk("mr_ovf0",     {31'b0, overflow},  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            chk("mr_quiet_tx",   {31'b0, tx},   32'd1);
            chk("mr_quiet_busy", {31'b0, busy}, 32'd0);
        end

        // Pointer wrap: 40 paced bytes
        wr(32'h00);
        @(negedge clk);
        for (int k = 0; k < 40; k++)
            check_frame(8'(k), (k < 39), 8'(k + 1), "wrap_frame");
        chk("wrap_busy", {31'b0, busy},     32'd0);
        chk("wrap_ovf",  {31'b0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
